// File: rtl/datapath_pkg.sv
// Shared datapath definitions: FunSel operation encodings used by the register
// files, IR and ARF, plus a constant-evaluable ceiling log2.
package datapath_pkg;

  typedef enum logic [1:0] {
    FS_DEC   = 2'b00,
    FS_INC   = 2'b01,
    FS_LOAD  = 2'b10,
    FS_CLEAR = 2'b11
  } funsel_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/funsel_reg_cell.sv
// One FunSel-controlled register with restore path, forwarded next value and a
// registered wrap pulse raised after an INC of all-ones or a DEC of zero.
module funsel_reg_cell
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_en,
  input  logic [1:0]       i_funsel,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_restore,
  input  logic [WIDTH-1:0] i_restore_val,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap_next;

  // Next value ignores RST; the reset override happens at the flop so o_next
  // stays a pure function of the write/restore request.
  always_comb begin
    w_next      = r_q;
    w_wrap_next = 1'b0;
    if (i_restore) begin
      w_next = i_restore_val;
    end else if (i_en) begin
      case (funsel_e'(i_funsel))
        FS_DEC: begin
          w_next      = r_q - 1'b1;
          w_wrap_next = (r_q == '0);
        end
        FS_INC: begin
          w_next      = r_q + 1'b1;
          w_wrap_next = (r_q == '1);
        end
        FS_LOAD:  w_next = i_data;
        FS_CLEAR: w_next = '0;
        default:  w_next = r_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign o_q    = r_q;
  assign o_next = w_next;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/param_reg_file.sv
// Parametrised general/temporary register file: masked FunSel writes, two read
// ports with optional write bypass, per-register wrap pulses and a shadow bank.
module param_reg_file
  import datapath_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned NREGS  = 4,
  parameter  int unsigned NTEMP  = 4,
  parameter  int unsigned BYPASS = 0,
  localparam int unsigned NTOT   = NREGS + NTEMP,
  localparam int unsigned SELW   = (NTOT > 1) ? clog2(NTOT) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       FunSel,
  input  logic [NREGS-1:0] RegSel,
  input  logic [NTEMP-1:0] TSel,
  input  logic [WIDTH-1:0] I,
  input  logic [SELW-1:0]  O1Sel,
  input  logic [SELW-1:0]  O2Sel,
  input  logic             Save,
  input  logic             Restore,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [NTOT-1:0]  Wrap
);

  logic [NTOT-1:0]  w_mask;
  logic [WIDTH-1:0] w_q      [NTOT];
  logic [WIDTH-1:0] w_next   [NTOT];
  logic [WIDTH-1:0] w_rd     [NTOT];
  logic [WIDTH-1:0] r_shadow [NTOT];

  assign w_mask = {TSel, RegSel};

  for (genvar g = 0; g < NTOT; g++) begin : g_cell
    funsel_reg_cell #(.WIDTH(WIDTH)) u_cell (
      .CLK           (CLK),
      .RST           (RST),
      .i_en          (w_mask[g]),
      .i_funsel      (FunSel),
      .i_data        (I),
      .i_restore     (Restore),
      .i_restore_val (r_shadow[g]),
      .o_q           (w_q[g]),
      .o_next        (w_next[g]),
      .o_wrap        (Wrap[g])
    );

    // Cell next value already equals state when idle and shadow on Restore.
    always_comb begin
      w_rd[g] = ((BYPASS != 0) && !RST) ? w_next[g] : w_q[g];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NTOT; i++) r_shadow[i] <= '0;
    end else if (Save && !Restore) begin
      for (int unsigned i = 0; i < NTOT; i++) r_shadow[i] <= w_q[i];
    end
  end

  // Scan instead of direct indexing so out-of-range selects read zero.
  always_comb begin
    O1 = '0;
    O2 = '0;
    for (int unsigned i = 0; i < NTOT; i++) begin
      if (32'(O1Sel) == i) O1 = w_rd[i];
      if (32'(O2Sel) == i) O2 = w_rd[i];
    end
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench for param_reg_file: default, bypass and NTEMP=5 instances.
module tb_param_reg_file;
  import datapath_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] FunSel = 2'b00;
  logic [3:0] RegSel = '0;
  logic [3:0] TSel = '0;
  logic [7:0] I = '0;
  logic [2:0] O1Sel = '0, O2Sel = '0, bp_sel = '0;
  logic       Save = 1'b0, Restore = 1'b0;
  logic [7:0] O1, O2, bO1, bO2, Wrap, bWrap;

  logic [4:0] TSel5 = '0;
  logic [3:0] O1Sel5 = '0, O2Sel5 = '0;
  logic       t5_save = 1'b0, t5_restore = 1'b0;
  logic [7:0] c_O1, c_O2;
  logic [8:0] c_Wrap;

  always #20 CLK = ~CLK;

  param_reg_file #(.WIDTH(8), .NREGS(4), .NTEMP(4), .BYPASS(0)) u_dut (
    .CLK(CLK), .RST(RST), .FunSel(FunSel), .RegSel(RegSel), .TSel(TSel), .I(I),
    .O1Sel(O1Sel), .O2Sel(O2Sel), .Save(Save), .Restore(Restore),
    .O1(O1), .O2(O2), .Wrap(Wrap));

  param_reg_file #(.WIDTH(8), .NREGS(4), .NTEMP(4), .BYPASS(1)) u_bp (
    .CLK(CLK), .RST(RST), .FunSel(FunSel), .RegSel(RegSel), .TSel(TSel), .I(I),
    .O1Sel(O1Sel), .O2Sel(bp_sel), .Save(Save), .Restore(Restore),
    .O1(bO1), .O2(bO2), .Wrap(bWrap));

  param_reg_file #(.WIDTH(8), .NREGS(4), .NTEMP(5), .BYPASS(0)) u_t5 (
    .CLK(CLK), .RST(RST), .FunSel(FunSel), .RegSel(RegSel), .TSel(TSel5), .I(I),
    .O1Sel(O1Sel5), .O2Sel(O2Sel5), .Save(t5_save), .Restore(t5_restore),
    .O1(c_O1), .O2(c_O2), .Wrap(c_Wrap));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0] m_r  [8];
  logic [7:0] m_sh [8];
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] fs, input logic [3:0] rs,
                      input logic [3:0] ts, input logic [7:0] d, input logic sv,
                      input logic rr, input logic [2:0] bsel);
    logic [7:0] n_r [8];
    logic [7:0] n_w;
    logic [7:0] msk;
    logic [7:0] e;
    @(negedge CLK);
    RST = rst; FunSel = fs; RegSel = rs; TSel = ts; I = d;
    Save = sv; Restore = rr; bp_sel = bsel; O2Sel = bsel;
    msk = {ts, rs};
    n_w = '0;
    for (int i = 0; i < 8; i++) n_r[i] = m_r[i];
    if (rst) begin
      for (int i = 0; i < 8; i++) n_r[i] = '0;
    end else if (rr) begin
      for (int i = 0; i < 8; i++) n_r[i] = m_sh[i];
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (msk[i]) begin
          case (fs)
            2'b00: begin n_r[i] = m_r[i] - 8'd1; n_w[i] = (m_r[i] == 8'h00); end
            2'b01: begin n_r[i] = m_r[i] + 8'd1; n_w[i] = (m_r[i] == 8'hFF); end
            2'b10: n_r[i] = d;
            default: n_r[i] = 8'h00;
          endcase
        end
      end
    end
    #1;
    if (!rst) begin
      chk($sformatf("bypass_o2[%0d]", bsel), bO2, n_r[bsel]);
      chk($sformatf("nobypass_o2[%0d]", bsel), O2, m_r[bsel]);
    end
    if (rst) for (int i = 0; i < 8; i++) m_sh[i] = '0;
    else if (sv && !rr) for (int i = 0; i < 8; i++) m_sh[i] = m_r[i];
    for (int i = 0; i < 8; i++) exp_q.push_back(n_r[i]);
    exp_q.push_back(n_w);
    for (int i = 0; i < 8; i++) m_r[i] = n_r[i];

    @(posedge CLK);
    #1;
    for (int k = 0; k < 8; k++) begin
      O1Sel = 3'(k); O2Sel = 3'(k);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("reg%0d_o1", k), O1, e);
      chk($sformatf("reg%0d_o2", k), O2, e);
    end
    e = exp_q.pop_front();
    chk("wrap", Wrap, e);
    chk("wrap_bypass_inst", bWrap, e);
    RST = 1'b0; RegSel = '0; TSel = '0; TSel5 = '0; Save = 1'b0; Restore = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m_r[i] = '0; m_sh[i] = '0; end

    step(1'b1, FS_INC, 4'hF, 4'hF, 8'h00, 1'b1, 1'b0, 3'd0);   // reset
    step(1'b0, FS_LOAD, 4'b0101, 4'b1000, 8'hAA, 1'b0, 1'b0, 3'd2);
    step(1'b0, FS_LOAD, 4'b0010, 4'b0000, 8'hFF, 1'b0, 1'b0, 3'd1);
    step(1'b0, FS_INC, 4'b0010, 4'b0000, 8'h00, 1'b0, 1'b0, 3'd1);
    step(1'b0, FS_DEC, 4'b0010, 4'b0000, 8'h00, 1'b0, 1'b0, 3'd1);
    step(1'b0, FS_INC, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 3'd1);
    step(1'b0, FS_LOAD, 4'b0001, 4'b0000, 8'h11, 1'b0, 1'b0, 3'd0);
    step(1'b0, FS_LOAD, 4'b0001, 4'b0000, 8'h22, 1'b1, 1'b0, 3'd0);
    step(1'b0, FS_LOAD, 4'b1111, 4'b1111, 8'h77, 1'b0, 1'b0, 3'd5);
    step(1'b0, FS_INC, 4'b0001, 4'b0000, 8'h00, 1'b0, 1'b1, 3'd0);
    step(1'b0, FS_CLEAR, 4'b1111, 4'b1111, 8'h00, 1'b0, 1'b0, 3'd3);
    step(1'b0, FS_INC, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, 3'd0);  // save ignored
    step(1'b0, FS_LOAD, 4'b1000, 4'b0000, 8'h10, 1'b0, 1'b0, 3'd3);
    step(1'b0, FS_INC, 4'b1000, 4'b0000, 8'h00, 1'b0, 1'b0, 3'd3);
    step(1'b0, FS_CLEAR, 4'b1111, 4'b1111, 8'h00, 1'b0, 1'b0, 3'd4);
    step(1'b0, FS_DEC, 4'b1111, 4'b1111, 8'h00, 1'b0, 1'b0, 3'd6);
    step(1'b0, FS_INC, 4'b1111, 4'b1111, 8'h00, 1'b1, 1'b0, 3'd7);
    step(1'b0, FS_LOAD, 4'b0000, 4'b0000, 8'h55, 1'b0, 1'b1, 3'd2);
    step(1'b1, FS_LOAD, 4'b1111, 4'b1111, 8'h99, 1'b1, 1'b0, 3'd0);  // reset mid-sequence
    step(1'b0, FS_INC, 4'b1111, 4'b1111, 8'h00, 1'b0, 1'b1, 3'd1);   // shadow cleared
    for (int n = 0; n < 24; n++) begin
      step(($urandom_range(0, 15) == 0), 2'($urandom), 4'($urandom), 4'($urandom),
           8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           3'($urandom));
    end

    // NTEMP=5 instance: T4 at index 8, index 9 and above read zero.
    @(negedge CLK);
    TSel5 = 5'b10000;
    step(1'b0, FS_LOAD, 4'b0000, 4'b0000, 8'h5C, 1'b0, 1'b0, 3'd0);
    O1Sel5 = 4'd8; O2Sel5 = 4'd8;
    #1;
    chk("t5_o1_sel8", c_O1, 8'h5C);
    chk("t5_o2_sel8", c_O2, 8'h5C);
    O1Sel5 = 4'd9; O2Sel5 = 4'd15;
    #1;
    chk("t5_o1_sel9", c_O1, 8'h00);
    chk("t5_o2_sel15", c_O2, 8'h00);
    chk("t5_wrap", c_Wrap, 9'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
